// File: rtl/async_harness_pkg.sv
// -----------------------------------------------------------------------------
// async_harness_pkg
// Shared types and width helpers for the asynchronous stutter harness.
//   state_e  : harness FSM states (CAPTURE, RUN, DONE)
//   step_w   : width of a step counter able to hold 0..steps
//   stall_w  : width of a stall counter able to hold 0..max_st (minimum 1)
// -----------------------------------------------------------------------------
package async_harness_pkg;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2
   } state_e;

   function automatic int step_w(input int steps);
      return $clog2(steps + 1);
   endfunction

   // A bound of 0 still needs a 1-bit counter so the compare has an operand.
   function automatic int stall_w(input int max_st);
      return (max_st < 1) ? 1 : $clog2(max_st + 1);
   endfunction

endpackage

// File: rtl/stutter_channel.sv
// -----------------------------------------------------------------------------
// stutter_channel
// One independently stuttering channel: step counter, consecutive-stall
// counter, done flag and the en/st/forced decode for the current cycle.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   run          : harness is in RUN (channel may step or stall)
//   clear        : restart accepted; zero step/stall/done on next edge
//   stutter      : stall request for this cycle
//   en, st       : step taken / stall taken this cycle (combinational)
//   forced       : step taken although stutter=1 (bound hit)
//   done         : registered completion flag (step == STEPS)
//   done_next    : value done will take at the next edge
//   step         : step counter
// -----------------------------------------------------------------------------
module stutter_channel
   import async_harness_pkg::*;
#(
   parameter int STEPS       = 8,
   parameter int MAX_STUTTER = 3,
   parameter int STEP_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              clear,
   input  logic              stutter,
   output logic              en,
   output logic              st,
   output logic              forced,
   output logic              done,
   output logic              done_next,
   output logic [STEP_W-1:0] step
);

   localparam int                STALL_W = stall_w(MAX_STUTTER);
   localparam logic [STALL_W-1:0] BOUND  = STALL_W'(MAX_STUTTER);
   localparam logic [STEP_W-1:0]  STEPS_C = STEP_W'(STEPS);

   logic [STEP_W-1:0]  step_q, step_d;
   logic [STALL_W-1:0] stcnt_q, stcnt_d;
   logic               done_q, done_d;
   logic               bound;

   always_comb begin
      en      = 1'b0;
      st      = 1'b0;
      forced  = 1'b0;
      step_d  = step_q;
      stcnt_d = stcnt_q;
      done_d  = done_q;
      // With MAX_STUTTER=0 the counter never leaves 0, so every stutter is forced.
      bound   = (stcnt_q == BOUND);
      if (clear) begin
         step_d  = '0;
         stcnt_d = '0;
         done_d  = 1'b0;
      end else if (run && !done_q) begin
         en     = !stutter || bound;
         st     = stutter && !bound;
         forced = stutter && bound;
         if (en) begin
            step_d  = step_q + STEP_W'(1);
            stcnt_d = '0;
            done_d  = (step_d == STEPS_C);
         end else begin
            stcnt_d = stcnt_q + STALL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q  <= '0;
         stcnt_q <= '0;
         done_q  <= 1'b0;
      end else begin
         step_q  <= step_d;
         stcnt_q <= stcnt_d;
         done_q  <= done_d;
      end
   end

   assign step      = step_q;
   assign done      = done_q;
   assign done_next = done_d;

endmodule

// File: rtl/async_stutter_harness.sv
// -----------------------------------------------------------------------------
// async_stutter_harness
// Captures one input snapshot after reset, then runs NUM_CH bounded-stutter
// channels until each has taken STEPS steps. Downstream models step on ch_en.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   init_data   : symbolic initial inputs, sampled in CAPTURE only
//   restart     : re-capture request, honoured in DONE when RESTART_EN=1
//   stutter     : per-channel stall request
//   snap_data   : captured snapshot;  snap_valid : snapshot held
//   ch_en/ch_st/ch_forced : per-channel step/stall/forced-step this cycle
//   ch_step     : packed step counters, channel i at [i*STEP_W +: STEP_W]
//   ch_done     : per-channel completion
//   aligned     : all step counters equal;  all_done : state is DONE
// -----------------------------------------------------------------------------
module async_stutter_harness
   import async_harness_pkg::*;
#(
   parameter int IN_W        = 4,
   parameter int NUM_CH      = 2,
   parameter int STEPS       = 8,
   parameter int MAX_STUTTER = 3,
   parameter int RESTART_EN  = 1,
   localparam int STEP_W     = step_w(STEPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [IN_W-1:0]          init_data,
   input  logic                     restart,
   input  logic [NUM_CH-1:0]        stutter,
   output logic [IN_W-1:0]          snap_data,
   output logic                     snap_valid,
   output logic [NUM_CH-1:0]        ch_en,
   output logic [NUM_CH-1:0]        ch_st,
   output logic [NUM_CH-1:0]        ch_forced,
   output logic [NUM_CH*STEP_W-1:0] ch_step,
   output logic [NUM_CH-1:0]        ch_done,
   output logic                     aligned,
   output logic                     all_done
);

   state_e            state_q, state_d;
   logic [IN_W-1:0]   snap_data_q, snap_data_d;
   logic              snap_valid_q, snap_valid_d;
   logic              clear;
   logic              run;
   logic [NUM_CH-1:0] done_next;

   assign run = (state_q == RUN);

   always_comb begin
      state_d      = state_q;
      snap_data_d  = snap_data_q;
      snap_valid_d = snap_valid_q;
      clear        = 1'b0;
      case (state_q)
         CAPTURE: begin
            snap_data_d  = init_data;
            snap_valid_d = 1'b1;
            state_d      = RUN;
         end
         RUN: begin
            // done_next includes channels finishing on this very edge.
            if (&done_next) state_d = DONE;
         end
         DONE: begin
            if (restart && (RESTART_EN != 0)) begin
               state_d      = CAPTURE;
               snap_valid_d = 1'b0;
               clear        = 1'b1;
            end
         end
         default: state_d = CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= CAPTURE;
         snap_data_q  <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_data_q  <= snap_data_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      stutter_channel #(
         .STEPS       (STEPS),
         .MAX_STUTTER (MAX_STUTTER),
         .STEP_W      (STEP_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .run       (run),
         .clear     (clear),
         .stutter   (stutter[gi]),
         .en        (ch_en[gi]),
         .st        (ch_st[gi]),
         .forced    (ch_forced[gi]),
         .done      (ch_done[gi]),
         .done_next (done_next[gi]),
         .step      (ch_step[gi*STEP_W +: STEP_W])
      );
   end

   always_comb begin
      aligned = 1'b1;
      for (int i = 1; i < NUM_CH; i++) begin
         if (ch_step[i*STEP_W +: STEP_W] != ch_step[0 +: STEP_W]) aligned = 1'b0;
      end
   end

   assign snap_data  = snap_data_q;
   assign snap_valid = snap_valid_q;
   assign all_done   = (state_q == DONE);

endmodule

// File: tb/tb_async_stutter_harness.sv
module tb_async_stutter_harness;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] init_data;
   logic       restart;
   logic [1:0] stutter;
   logic [1:0] ms0_stutter;

   // default instance
   logic [3:0] snap_data;
   logic       snap_valid, aligned, all_done;
   logic [1:0] ch_en, ch_st, ch_forced, ch_done;
   logic [7:0] ch_step;

   // RESTART_EN=0 instance
   logic [3:0] nr_snap_data;
   logic       nr_snap_valid, nr_aligned, nr_all_done;
   logic [1:0] nr_ch_en, nr_ch_st, nr_ch_forced, nr_ch_done;
   logic [7:0] nr_ch_step;

   // MAX_STUTTER=0 instance
   logic [3:0] ms_snap_data;
   logic       ms_snap_valid, ms_aligned, ms_all_done;
   logic [1:0] ms_ch_en, ms_ch_st, ms_ch_forced, ms_ch_done;
   logic [7:0] ms_ch_step;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   async_stutter_harness dut (
      .clk(clk), .rst_n(rst_n), .init_data(init_data), .restart(restart),
      .stutter(stutter), .snap_data(snap_data), .snap_valid(snap_valid),
      .ch_en(ch_en), .ch_st(ch_st), .ch_forced(ch_forced), .ch_step(ch_step),
      .ch_done(ch_done), .aligned(aligned), .all_done(all_done)
   );

   async_stutter_harness #(.RESTART_EN(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .init_data(init_data), .restart(restart),
      .stutter(stutter), .snap_data(nr_snap_data), .snap_valid(nr_snap_valid),
      .ch_en(nr_ch_en), .ch_st(nr_ch_st), .ch_forced(nr_ch_forced),
      .ch_step(nr_ch_step), .ch_done(nr_ch_done), .aligned(nr_aligned),
      .all_done(nr_all_done)
   );

   async_stutter_harness #(.MAX_STUTTER(0)) dut_ms0 (
      .clk(clk), .rst_n(rst_n), .init_data(init_data), .restart(restart),
      .stutter(ms0_stutter), .snap_data(ms_snap_data), .snap_valid(ms_snap_valid),
      .ch_en(ms_ch_en), .ch_st(ms_ch_st), .ch_forced(ms_ch_forced),
      .ch_step(ms_ch_step), .ch_done(ms_ch_done), .aligned(ms_aligned),
      .all_done(ms_all_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_snap_data"},  32'(snap_data),  32'h0);
      chk({tag, "_snap_valid"}, 32'(snap_valid), 32'h0);
      chk({tag, "_ch_step"},    32'(ch_step),    32'h0);
      chk({tag, "_ch_done"},    32'(ch_done),    32'h0);
      chk({tag, "_ch_en"},      32'(ch_en),      32'h0);
      chk({tag, "_all_done"},   32'(all_done),   32'h0);
   endtask

   initial begin
      rst_n       = 1'b0;
      init_data   = 4'hA;
      restart     = 1'b0;
      stutter     = 2'b00;
      ms0_stutter = 2'b11;
      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      chk("rst_aligned", 32'(aligned), 32'h1);

      // Release reset; the first edge captures, the next cycle is RUN.
      rst_n = 1'b1;
      @(negedge clk);
      chk("cap_snap_data",  32'(snap_data),  32'hA);
      chk("cap_snap_valid", 32'(snap_valid), 32'h1);

      for (int k = 0; k < 8; k++) begin
         chk("run_ch_en",   32'(ch_en),   32'h3);
         chk("run_ch_step", 32'(ch_step), 32'((k << 4) | k));
         chk("run_aligned", 32'(aligned), 32'h1);
         chk("ms0_ch_en",     32'(ms_ch_en),     32'h3);
         chk("ms0_ch_forced", 32'(ms_ch_forced), 32'h3);
         chk("ms0_ch_st",     32'(ms_ch_st),     32'h0);
         if (k == 3) init_data = 4'h5;
         @(negedge clk);
      end
      chk("done_all_done",  32'(all_done),  32'h1);
      chk("done_ch_step",   32'(ch_step),   32'h88);
      chk("done_ch_done",   32'(ch_done),   32'h3);
      chk("done_ch_en",     32'(ch_en),     32'h0);
      chk("done_snap_hold", 32'(snap_data), 32'hA);
      chk("ms0_all_done",   32'(ms_all_done), 32'h1);
      chk("nr_all_done",    32'(nr_all_done), 32'h1);

      // Stutter in DONE must not disturb anything.
      stutter = 2'b11;
      @(negedge clk);
      chk("done_stut_en",   32'(ch_en | ch_st | ch_forced), 32'h0);
      chk("done_stut_step", 32'(ch_step), 32'h88);

      // Restart from DONE with new inputs.
      restart   = 1'b1;
      init_data = 4'h3;
      stutter   = 2'b00;
      @(negedge clk);
      restart = 1'b0;
      stutter = 2'b01;
      chk("rs_all_done",   32'(all_done),   32'h0);
      chk("rs_ch_step",    32'(ch_step),    32'h0);
      chk("rs_ch_done",    32'(ch_done),    32'h0);
      chk("rs_snap_valid", 32'(snap_valid), 32'h0);
      chk("rs_ch_en",      32'(ch_en),      32'h0);
      chk("nr_stay_done",  32'(nr_all_done), 32'h1);
      chk("nr_step_hold",  32'(nr_ch_step),  32'h88);
      chk("nr_snap_hold",  32'(nr_snap_data), 32'hA);
      @(negedge clk);
      chk("rs_snap_data",  32'(snap_data),  32'h3);
      chk("rs_snap_valid1", 32'(snap_valid), 32'h1);

      // Channel 0 stutters continuously: three stalls then a forced step.
      for (int r = 0; r < 32; r++) begin
         int s0, s1;
         s0 = r / 4;
         s1 = (r < 8) ? r : 8;
         chk("bs_ch_st",     32'(ch_st),     32'((r % 4 != 3) ? 1 : 0));
         chk("bs_ch_forced", 32'(ch_forced), 32'((r % 4 == 3) ? 1 : 0));
         chk("bs_ch_en",     32'(ch_en),     32'(((r < 8) ? 2 : 0) | ((r % 4 == 3) ? 1 : 0)));
         chk("bs_ch_step",   32'(ch_step),   32'((s1 << 4) | s0));
         chk("bs_aligned",   32'(aligned),   32'((s0 == s1) ? 1 : 0));
         chk("bs_ch_done",   32'(ch_done),   32'((r >= 8) ? 2 : 0));
         chk("bs_all_done",  32'(all_done),  32'h0);
         restart = (r == 10);
         @(negedge clk);
      end
      restart = 1'b0;
      chk("bs_end_all_done", 32'(all_done), 32'h1);
      chk("bs_end_ch_done",  32'(ch_done),  32'h3);
      chk("bs_end_ch_step",  32'(ch_step),  32'h88);

      // Build up ch_step = {3,5}, then reset mid-run.
      restart = 1'b1;
      stutter = 2'b00;
      @(negedge clk);
      restart = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      stutter = 2'b10;
      repeat (2) @(negedge clk);
      chk("mr_ch_step", 32'(ch_step), 32'h35);
      chk("mr_aligned", 32'(aligned), 32'h0);
      rst_n   = 1'b0;
      stutter = 2'b00;
      @(negedge clk);
      chk_reset_state("mr");
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_rel_ch_en",   32'(ch_en),     32'h3);
      chk("mr_rel_ch_step", 32'(ch_step),   32'h0);
      chk("mr_rel_snap",    32'(snap_data), 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
